// File: rtl/fp16_to_int_if.sv
// Purpose: request/result handshake bundle between an FP16 producer and fp16_to_int.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request side and the result side.
interface fp16_to_int_if #(
  parameter int OUT_W = 16
);
  // request side
  logic             valid_i;
  logic             ready_o;
  logic [15:0]      fp_i;
  // result side
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] int_o;
  logic             ovf_o;
  logic             inv_o;
  logic             inexact_o;

  // The master issues conversion requests and consumes results.
  modport master (
    output valid_i, fp_i, ready_i,
    input  ready_o, valid_o, int_o, ovf_o, inv_o, inexact_o
  );

  // The converter side.
  modport slave (
    input  valid_i, fp_i, ready_i,
    output ready_o, valid_o, int_o, ovf_o, inv_o, inexact_o
  );
endinterface

// File: rtl/fp16_to_int.sv
// Purpose: FP16 -> signed OUT_W-bit integer, round toward zero, saturating, with invalid/inexact flags.
// Latency: result valid N+1 edges after accept, N = |exp-25| for 15<=exp<=30, else 0 (worst case 11).
// Backpressure: one op in flight; no accept until the held result is taken (valid_o && ready_i).
module fp16_to_int #(
  parameter int OUT_W = 16
) (
  input logic          clk_i,
  input logic          rstn_i,
  fp16_to_int_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturation thresholds on the unsigned magnitude, held in 33 bits so OUT_W=32 fits.
  localparam logic [32:0] MAX_POS = (33'd1 << (OUT_W - 1)) - 33'd1;
  localparam logic [32:0] MAX_NEG = 33'd1 << (OUT_W - 1);

  // Saturated result patterns: 0111..1 and 1000..0.
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W - 1){1'b0}}};

  state_t           state;
  logic [16:0]      mag;       // integer magnitude being aligned
  logic [3:0]       cnt;       // remaining single-bit shifts
  logic             dir_left;  // 1: scale up (exp > 25), 0: scale down
  logic             sign;
  logic             sticky;    // any 1 bit discarded so far
  logic             is_nan;
  logic             is_inf;

  logic [OUT_W-1:0] int_q;
  logic             ovf_q;
  logic             inv_q;
  logic             inex_q;

  // Operand decode.
  logic [4:0]       in_exp;
  logic [9:0]       in_frac;
  logic             in_hidden;
  logic [3:0]       rsh_amt;
  logic [3:0]       lsh_amt;

  assign in_exp    = bus.fp_i[14:10];
  assign in_frac   = bus.fp_i[9:0];
  assign in_hidden = (in_exp != 5'd0);
  // Only consumed in the exponent ranges where they fit in 4 bits.
  assign rsh_amt   = 4'(5'd25 - in_exp);
  assign lsh_amt   = 4'(in_exp - 5'd25);

  // Finalize: compare the aligned magnitude against the signed range.
  logic [32:0]      mag_ext;
  logic [OUT_W-1:0] mag_w;
  logic             sat;
  logic [OUT_W-1:0] fin_val;

  assign mag_ext = {16'd0, mag};
  assign mag_w   = OUT_W'(mag);
  assign sat     = is_inf | (sign ? (mag_ext > MAX_NEG) : (mag_ext > MAX_POS));

  // Pick the final integer: zero for NaN, clamp on saturation, else signed magnitude.
  always_comb begin
    fin_val = '0;
    if (is_nan) begin
      fin_val = '0;
    end else if (sat) begin
      fin_val = sign ? SAT_NEG : SAT_POS;
    end else begin
      // -0 has mag==0, so negating it still yields 0.
      fin_val = sign ? (-mag_w) : mag_w;
    end
  end

  // Control FSM plus datapath registers: accept, iterate the shifter, hold the result.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      mag      <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
      sign     <= 1'b0;
      sticky   <= 1'b0;
      is_nan   <= 1'b0;
      is_inf   <= 1'b0;
      int_q    <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      inex_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            sign     <= bus.fp_i[15];
            sticky   <= 1'b0;
            is_nan   <= 1'b0;
            is_inf   <= 1'b0;
            dir_left <= 1'b0;
            cnt      <= '0;
            mag      <= '0;
            state    <= SHIFT;
            if (in_exp == 5'd31) begin
              // NaN or Inf: no alignment needed, finalize acts on the class bits.
              is_nan <= (in_frac != 10'd0);
              is_inf <= (in_frac == 10'd0);
            end else if (in_exp < 5'd15) begin
              // |x| < 1 truncates to zero; anything nonzero was lost.
              sticky <= (bus.fp_i[14:0] != 15'd0);
            end else if (in_exp <= 5'd25) begin
              mag <= {6'd0, in_hidden, in_frac};
              cnt <= rsh_amt;
            end else begin
              mag      <= {6'd0, in_hidden, in_frac};
              cnt      <= lsh_amt;
              dir_left <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (cnt != 4'd0) begin
            if (dir_left) begin
              mag <= {mag[15:0], 1'b0};
            end else begin
              mag    <= {1'b0, mag[16:1]};
              sticky <= sticky | mag[0];
            end
            cnt <= cnt - 4'd1;
          end else begin
            int_q  <= fin_val;
            inv_q  <= is_nan;
            ovf_q  <= ~is_nan & sat;
            inex_q <= ~is_nan & sticky;
            state  <= DONE;
          end
        end

        DONE: begin
          if (bus.ready_i) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o   = (state == IDLE);
  assign bus.valid_o   = (state == DONE);
  assign bus.int_o     = int_q;
  assign bus.ovf_o     = ovf_q;
  assign bus.inv_o     = inv_q;
  assign bus.inexact_o = inex_q;

endmodule

// File: tb/tb_fp16_to_int.sv
// Purpose: self-checking bench for fp16_to_int at OUT_W=16 and OUT_W=32 running in lockstep.
// Latency: checks the exact accept-to-valid edge count of every conversion.
// Backpressure: exercises held results, blocked requests and reset mid-conversion.
module tb_fp16_to_int;

  logic clk = 1'b0;
  logic rstn;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fp16_to_int_if #(.OUT_W(16)) b16 ();
  fp16_to_int_if #(.OUT_W(32)) b32 ();

  fp16_to_int #(.OUT_W(16)) dut16 (.clk_i(clk), .rstn_i(rstn), .bus(b16));
  fp16_to_int #(.OUT_W(32)) dut32 (.clk_i(clk), .rstn_i(rstn), .bus(b32));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: exact value of the FP16 number, truncated and clamped with plain arithmetic.
  function automatic void ref_conv(input logic [15:0] fp, input int ow, output logic [31:0] res,
                                   output logic ovf, output logic inv, output logic inex,
                                   output int lat);
    longint e, f, m, mag, v, maxp, minn;
    logic [63:0] bits;
    e    = longint'(fp[14:10]);
    f    = longint'(fp[9:0]);
    maxp = (longint'(1) << (ow - 1)) - 1;
    minn = -maxp - 1;
    ovf = 1'b0; inv = 1'b0; inex = 1'b0; lat = 1; mag = 0; v = 0;
    if (e == 31) begin
      if (f != 0) inv = 1'b1;
      else begin
        ovf = 1'b1;
        v   = fp[15] ? minn : maxp;
      end
    end else begin
      if (e != 0) begin
        m = 1024 + f;
        if (e >= 25) mag = m << (e - 25);
        else begin
          mag  = m >> (25 - e);
          inex = (m % (longint'(1) << (25 - e))) != 0;
        end
        if (e >= 15) lat = 1 + ((e >= 25) ? int'(e - 25) : int'(25 - e));
      end else begin
        inex = (f != 0);
      end
      v = fp[15] ? -mag : mag;
      if (v > maxp) begin v = maxp; ovf = 1'b1; end
      if (v < minn) begin v = minn; ovf = 1'b1; end
    end
    bits = v;
    res  = bits[31:0];
    if (ow < 32) res = res & ((32'd1 << ow) - 32'd1);
  endfunction

  task automatic drive(input logic v, input logic [15:0] fp);
    b16.valid_i = v; b32.valid_i = v;
    b16.fp_i    = fp; b32.fp_i   = fp;
  endtask

  task automatic set_rdy(input logic r);
    b16.ready_i = r; b32.ready_i = r;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] fp);
    logic [31:0] r;
    logic o, i, x;
    int lat;
    ref_conv(fp, 16, r, o, i, x, lat);
    chk({tag, ".int16"}, {16'd0, b16.int_o}, r);
    chk({tag, ".ovf16"}, 32'(b16.ovf_o), 32'(o));
    chk({tag, ".inv16"}, 32'(b16.inv_o), 32'(i));
    chk({tag, ".inx16"}, 32'(b16.inexact_o), 32'(x));
    ref_conv(fp, 32, r, o, i, x, lat);
    chk({tag, ".int32"}, b32.int_o, r);
    chk({tag, ".ovf32"}, 32'(b32.ovf_o), 32'(o));
    chk({tag, ".inv32"}, 32'(b32.inv_o), 32'(i));
    chk({tag, ".inx32"}, 32'(b32.inexact_o), 32'(x));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".int16"}, {16'd0, b16.int_o}, 32'd0);
    chk({tag, ".int32"}, b32.int_o, 32'd0);
    chk({tag, ".flags"}, {29'd0, b16.ovf_o | b32.ovf_o, b16.inv_o | b32.inv_o,
                          b16.inexact_o | b32.inexact_o}, 32'd0);
    chk({tag, ".valid"}, {30'd0, b16.valid_o, b32.valid_o}, 32'd0);
    chk({tag, ".ready"}, {30'd0, b16.ready_o, b32.ready_o}, 32'd3);
  endtask

  // Starts at a negedge with the converter idle; returns at the negedge where valid_o is seen.
  task automatic convert(input string tag, input logic [15:0] fp);
    int edges, lat;
    logic [31:0] r;
    logic o, i, x;
    chk({tag, ".rdy_in"}, {30'd0, b16.ready_o, b32.ready_o}, 32'd3);
    drive(1'b1, fp);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 16'($urandom));
    edges = 0;
    while (!b16.valid_o && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    ref_conv(fp, 16, r, o, i, x, lat);
    chk({tag, ".latency"}, 32'(edges), 32'(lat));
    chk({tag, ".valid32"}, 32'(b32.valid_o), 32'd1);
    check_outs(tag, fp);
  endtask

  // Full conversion with ready_i high: result handed off on the edge after valid_o.
  task automatic run(input string tag, input logic [15:0] fp);
    convert(tag, fp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".handoff"}, {30'd0, b16.valid_o, b32.valid_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fp;
    logic [4:0]  ex;

    rstn = 1'b1;
    drive(1'b0, 16'h0000);
    set_rdy(1'b1);
    #1 rstn = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run("one",      16'h3C00);
    run("two_half", 16'h4100);
    run("neg_1p5",  16'hBE00);
    run("max_fp",   16'h7BFF);
    run("neg_32k",  16'hF800);
    run("neg_inf",  16'hFC00);
    run("pos_inf",  16'h7C00);
    run("nan",      16'h7E00);
    run("subnorm",  16'h0001);
    run("neg_zero", 16'h8000);
    run("zero",     16'h0000);
    run("half",     16'h3800);
    run("e25",      16'h67FF);

    // Backpressure: result held, new requests blocked.
    set_rdy(1'b0);
    convert("bp", 16'h4000);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'($urandom));
      @(posedge clk);
      @(negedge clk);
      chk("bp.valid_held", {30'd0, b16.valid_o, b32.valid_o}, 32'd3);
      chk("bp.ready_low", {30'd0, b16.ready_o, b32.ready_o}, 32'd0);
      check_outs("bp.hold", 16'h4000);
    end
    set_rdy(1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 16'h0000);
    chk("bp.idle_ready", {30'd0, b16.ready_o, b32.ready_o}, 32'd3);
    chk("bp.idle_valid", {30'd0, b16.valid_o, b32.valid_o}, 32'd0);
    run("after_bp", 16'h4900);

    // Reset in the middle of a conversion.
    drive(1'b1, 16'h3C00);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midreset.ready", {30'd0, b16.ready_o, b32.ready_o}, 32'd3);
    run("post_reset", 16'h4900);

    // Random operands, biased toward the shifting exponent range.
    for (int n = 0; n < 300; n++) begin
      fp = 16'($urandom);
      if (n % 2 == 0) begin
        ex = 5'($urandom_range(14, 31));
        fp[14:10] = ex;
      end
      run("rand", fp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp16_to_int.md
Name: fp16_to_int

Overview:
- Multi-cycle converter from IEEE-754 binary16 (the FP16 format produced by the team's FPADD unit) to a signed two's-complement integer. It is the decode direction of the FP16 datapath.
- Rounds toward zero, saturates on overflow, and flags invalid and inexact results.
- Uses an iterative single-bit shifter, with valid/ready handshakes on both the input and output sides.
- Sits between FP16 arithmetic results and integer consumers such as address, index and count logic.

Parameters:
- OUT_W, 16, width of the signed integer result; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- valid_i  input  1  fp_i holds a conversion request.
- ready_o  output  1  converter can accept a request.
- fp_i  input  16  FP16 operand {sign, exp[4:0], frac[9:0]}.
- valid_o  output  1  result is valid; held until taken.
- ready_i  input  1  consumer takes the result.
- int_o  output  OUT_W  signed integer result.
- ovf_o  output  1  result was saturated.
- inv_o  output  1  operand was NaN.
- inexact_o  output  1  nonzero fraction bits were discarded.

Behaviour:
- States: IDLE, SHIFT, DONE.
- ready_o = (state==IDLE).
- valid_o = (state==DONE).
- There is no input/output overlap: a new request is never accepted in the same cycle a result is handed off.

Reset (rstn_i low, at any time including mid-conversion):
- State goes to IDLE and the conversion in progress is discarded.
- int_o=0, ovf_o=0, inv_o=0, inexact_o=0, valid_o=0.

Accept (IDLE and valid_i):
- Latch the sign, and m = {hidden, frac}, an 11-bit value where hidden = (exp!=0), into a 17-bit magnitude register mag.
- Clear the sticky inexact bit.
- Set shift count N and direction by exponent e:
  - e==31, frac!=0 (NaN): N=0; result 0, inv=1.
  - e==31, frac==0 (Inf): N=0; saturate toward the sign, ovf=1.
  - e<15 (|x|<1, includes zero and subnormals): N=0; mag=0; inexact=1 if {exp,frac}!=0.
  - 15<=e<=25: right shift, N=25-e (0..10).
  - 26<=e<=30: left shift, N=e-25 (1..5).
- The next state is SHIFT.

SHIFT state:
- While the count is nonzero: shift mag one bit per cycle in the latched direction and decrement the count.
- On a right shift, OR the bit shifted out into sticky inexact.
- When the count is 0: finalize, load the output registers, and go to DONE.

Finalize:
- Positive operand: if mag > 2^(OUT_W-1)-1, then int_o = 2^(OUT_W-1)-1 and ovf=1.
- Negative operand: if mag > 2^(OUT_W-1), then int_o = -2^(OUT_W-1) and ovf=1.
- Otherwise int_o = sign ? -mag : mag.
- -0 converts to 0.

Latency:
- valid_o rises N+1 edges after the accepting edge.
- Worst case is 11 edges, at e=15.

DONE state:
- Outputs are held stable while ready_i is low.
- valid_o && ready_i moves the state to IDLE.
- int_o and the flags keep their values until the next finalize; only valid_o qualifies them.

Other rules:
- valid_i or fp_i changing while not ready has no effect.
- ovf_o, inv_o and inexact_o are mutually consistent: inv_o=1 implies ovf_o=0 and inexact_o=0.

Test Plan (all with OUT_W=16 unless noted):
- 0x3C00 (1.0), ready_i=1:
  - valid_o exactly 11 edges after accept.
  - int_o=1, all flags 0.
- 0x4100 (2.5) -> int_o=2, inexact=1.
- 0xBE00 (-1.5) -> int_o=0xFFFF (-1), inexact=1.
- 0x7BFF (65504):
  - -> int_o=0x7FFF, ovf=1.
  - With OUT_W=32 -> 65504, ovf=0.
- 0xF800 (-32768) -> int_o=0x8000, ovf=0.
- 0xFC00 (-Inf) -> 0x8000, ovf=1.
- 0x7E00 (NaN) -> int_o=0, inv=1.
- 0x0001 (subnormal):
  - valid_o 1 edge after accept.
  - int_o=0, inexact=1.
- 0x8000 (-0) -> 0, no flags.
- Backpressure on 0x4000 (2.0):
  - Hold ready_i=0 for 5 cycles: valid_o, int_o=2 and the flags stay stable, and ready_o stays 0 while a new valid_i is presented.
  - Raising ready_i gives IDLE on the next edge; the next request is accepted the cycle after that.
- Reset mid-op:
  - Accept 0x3C00, then drop rstn_i after 4 edges.
  - All outputs read 0 immediately and ready_o=1 after release.
  - A following 0x4900 (10.0) converts to 10 exactly.
